// File: rtl/rpll_cfg_pkg.sv
// Divider presets and sequencer state type shared by the rPLL reconfiguration logic.
package rpll_cfg_pkg;
    localparam int NUM_CFG   = 4;
    localparam int CFG_IDX_W = $clog2(NUM_CFG);

    typedef enum logic [2:0] {PRST, WLOCK, STABLE, READY, ERROR} pll_state_e;

    typedef struct packed {
        logic [5:0] idsel;
        logic [5:0] fbdsel;
        logic [5:0] odsel;
    } pll_codes_t;

    // Codes are ~(div-1). From a 27 MHz input, with IDIV/FBDIV/ODIV:
    // 0: 1/4/8 = 108 MHz, 1: 1/2/16 = 54 MHz, 2: 3/10/8 = 90 MHz, 3: 1/1/32 = 27 MHz
    localparam logic [5:0] IDSEL_TBL  [NUM_CFG] = '{6'd63, 6'd63, 6'd61, 6'd63};
    localparam logic [5:0] FBDSEL_TBL [NUM_CFG] = '{6'd60, 6'd62, 6'd54, 6'd63};
    localparam logic [5:0] ODSEL_TBL  [NUM_CFG] = '{6'd56, 6'd48, 6'd56, 6'd32};

    function automatic pll_codes_t preset_codes(input logic [CFG_IDX_W-1:0] idx);
        pll_codes_t c;
        c.idsel  = IDSEL_TBL[idx];
        c.fbdsel = FBDSEL_TBL[idx];
        c.odsel  = ODSEL_TBL[idx];
        return c;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], d};
    end

    assign q = sync_q[1];
endmodule

// File: rtl/rpll_reconfig_ctrl.sv
// rPLL sequencer: loads a divider preset, pulses RESET, waits for a stable
// LOCK with timeout/retry and then raises clk_ready.
module rpll_reconfig_ctrl #(
    parameter int NUM_CFG       = rpll_cfg_pkg::NUM_CFG,
    parameter int CFG_W         = 3,
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [CFG_W-1:0] req_cfg,
    output logic             req_ready,
    output logic             cfg_err,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic [5:0]       idsel,
    output logic [5:0]       fbdsel,
    output logic [5:0]       odsel,
    output logic [CFG_W-1:0] cur_cfg,
    output logic             clk_ready,
    output logic             busy,
    output logic             err
);
    import rpll_cfg_pkg::*;

    localparam int CNT_W = $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d, tmr_inc;
    logic [CNT_W-1:0] stab_q, stab_d, stab_inc;
    logic [RTY_W-1:0] retry_q, retry_d;
    pll_codes_t       codes_q;
    logic             lock_s, accept, cfg_ok;

    sync_2ff u_lock_sync (.clk(clk), .rst(rst), .d(pll_lock), .q(lock_s));

    assign accept   = req_valid && req_ready;
    assign cfg_ok   = int'(req_cfg) < NUM_CFG;
    assign tmr_inc  = (&tmr_q)  ? tmr_q  : tmr_q  + CNT_W'(1);
    assign stab_inc = (&stab_q) ? stab_q : stab_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        stab_d  = '0;
        retry_d = retry_q;
        unique case (state_q)
            PRST: begin
                tmr_d = tmr_inc;
                if (tmr_q >= RST_LAST) begin
                    state_d = WLOCK;
                    tmr_d   = '0;
                end
            end
            WLOCK: begin
                tmr_d = tmr_inc;
                if (lock_s) begin
                    state_d = STABLE;
                end else if (tmr_q >= TMO_LAST) begin
                    tmr_d   = '0;
                    retry_d = retry_q + RTY_W'(1);
                    state_d = (int'(retry_q) + 1 < MAX_RETRY) ? PRST : ERROR;
                end
            end
            // The lock timer is held here so a dropout resumes the same attempt budget.
            STABLE: begin
                if (!lock_s) begin
                    state_d = WLOCK;
                end else if (stab_q >= STB_LAST) begin
                    state_d = READY;
                    retry_d = '0;
                end else begin
                    stab_d = stab_inc;
                end
            end
            READY: begin
                if (!lock_s) begin
                    state_d = PRST;
                    tmr_d   = '0;
                end
            end
            ERROR: ;
            default: state_d = PRST;
        endcase
        if (accept && cfg_ok) begin
            state_d = PRST;
            tmr_d   = '0;
            retry_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PRST;
            tmr_q   <= '0;
            stab_q  <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            stab_q  <= stab_d;
            retry_q <= retry_d;
        end
    end

    // Outputs decode the next state so they are registered yet state-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            codes_q   <= preset_codes('0);
            cur_cfg   <= '0;
            pll_reset <= 1'b1;
            busy      <= 1'b1;
            clk_ready <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            pll_reset <= (state_d == PRST) || (state_d == ERROR);
            busy      <= !((state_d == READY) || (state_d == ERROR));
            req_ready <= (state_d == READY) || (state_d == ERROR);
            clk_ready <= state_d == READY;
            err       <= state_d == ERROR;
            cfg_err   <= accept && !cfg_ok;
            if (accept && cfg_ok) begin
                codes_q <= preset_codes(req_cfg[CFG_IDX_W-1:0]);
                cur_cfg <= req_cfg;
            end
        end
    end

    assign idsel  = codes_q.idsel;
    assign fbdsel = codes_q.fbdsel;
    assign odsel  = codes_q.odsel;
endmodule

// File: tb/tb_rpll_reconfig_ctrl.sv
// Bench for rpll_reconfig_ctrl: request table with a scoreboard plus lock/timeout/reset sequences.
module tb_rpll_reconfig_ctrl;
    localparam int LOCK_DLY = 6;

    logic       clk = 1'b0;
    logic       rst, req_valid, pll_lock;
    logic [2:0] req_cfg;
    logic       req_ready, cfg_err, pll_reset, clk_ready, busy, err;
    logic [5:0] idsel, fbdsel, odsel;
    logic [2:0] cur_cfg;

    typedef struct {
        logic [2:0] cfg;
        logic       exp_err;
        logic [2:0] exp_cur;
        logic       exp_rdy;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[5];
    int   n_chk = 0, n_pass = 0;
    int   plc = 0, drop_cnt = 0;
    logic pll_ok;

    always #5 clk = ~clk;

    rpll_reconfig_ctrl #(
        .RESET_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_cfg(req_cfg),
        .req_ready(req_ready), .cfg_err(cfg_err), .pll_lock(pll_lock),
        .pll_reset(pll_reset), .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel),
        .cur_cfg(cur_cfg), .clk_ready(clk_ready), .busy(busy), .err(err)
    );

    function automatic logic [17:0] exp_codes(input int c);
        int idiv[4] = '{1, 1, 3, 1};
        int fdiv[4] = '{4, 2, 10, 1};
        int odiv[4] = '{8, 16, 8, 32};
        logic [5:0] a, b, d;
        a = ~6'(idiv[c] - 1);
        b = ~6'(fdiv[c] - 1);
        d = ~6'(odiv[c] - 1);
        return {a, b, d};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // One clock: sample point is the falling edge; the PLL model updates lock there.
    task automatic step();
        @(negedge clk);
        if (pll_reset || !pll_ok) plc = 0;
        else if (plc < 1000) plc++;
        if (drop_cnt > 0) begin
            pll_lock = 1'b0;
            drop_cnt--;
        end else begin
            pll_lock = (plc >= LOCK_DLY);
        end
    endtask

    // Called on the first sample with pll_reset high; returns cycles until it falls.
    task automatic pulse_len(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (pll_reset && n < 50);
    endtask

    // Called on the first sample after pll_reset falls; returns cycles until clk_ready.
    task automatic wait_lock(input int drop_at, output int n);
        n = 0;
        while (!clk_ready && n < 200) begin
            if (n == drop_at) drop_cnt = 3;
            step();
            n++;
        end
    endtask

    task automatic do_req(input vec_t v);
        vec_t e;
        int   w, n;
        w = 0;
        while (!req_ready && w < 500) begin
            step();
            w++;
        end
        check("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_cfg   = v.cfg;
        sb.push_back(v);
        step();
        req_valid = 1'b0;
        e = sb.pop_front();
        check("cfg_err", cfg_err, e.exp_err);
        check("cur_cfg", cur_cfg, e.exp_cur);
        check("codes", {idsel, fbdsel, odsel}, exp_codes(int'(e.exp_cur)));
        check("clk_ready_after_req", clk_ready, e.exp_rdy);
        if (!e.exp_err) begin
            check("req_pll_reset", pll_reset, 1);
            check("req_err_clear", err, 0);
            check("req_busy", {busy, req_ready}, 2'b10);
            pulse_len(n);
            check("req_reset_pulse", n, 4);
        end else begin
            step();
            check("cfg_err_one_cycle", cfg_err, 0);
        end
    endtask

    initial begin
        int n;
        tbl = '{'{3'd2, 1'b0, 3'd2, 1'b0},
                '{3'd5, 1'b1, 3'd2, 1'b1},
                '{3'd0, 1'b0, 3'd0, 1'b0},
                '{3'd7, 1'b1, 3'd0, 1'b1},
                '{3'd3, 1'b0, 3'd3, 1'b0}};
        rst = 1'b1; req_valid = 1'b0; req_cfg = '0; pll_lock = 1'b0; pll_ok = 1'b1;
        repeat (3) step();
        check("rst_flags", {pll_reset, busy, clk_ready, err, req_ready, cfg_err}, 6'b110000);
        check("rst_codes", {idsel, fbdsel, odsel}, exp_codes(0));
        check("rst_cur_cfg", cur_cfg, 0);

        rst = 1'b0;
        pulse_len(n);
        check("pwrup_reset_pulse", n, 4);
        wait_lock(-1, n);
        check("pwrup_lock_latency", (n >= 15 && n <= 17), 1);
        check("pwrup_ready", {clk_ready, busy, req_ready}, 3'b101);
        check("pwrup_codes", {idsel, fbdsel, odsel}, exp_codes(0));

        foreach (tbl[i]) begin
            do_req(tbl[i]);
            if (!tbl[i].exp_err) begin
                wait_lock(-1, n);
                check("relock_latency", (n >= 15 && n <= 17), 1);
                check("relock_idle", {clk_ready, busy}, 2'b10);
            end
        end

        // Lock dropout while counting stability delays clk_ready.
        do_req('{3'd1, 1'b0, 3'd1, 1'b0});
        wait_lock(10, n);
        check("glitch_delay", (n >= 20 && n <= 27), 1);

        // Lock loss in READY restarts the sequence.
        drop_cnt = 3;
        step();
        n = 0;
        while (clk_ready && n < 20) begin
            step();
            n++;
        end
        check("ready_drop_latency", (n <= 3), 1);
        check("ready_drop_reset", {clk_ready, pll_reset}, 2'b01);
        pulse_len(n);
        check("ready_drop_pulse", n, 4);
        wait_lock(-1, n);
        check("ready_drop_relock", (n >= 15 && n <= 17), 1);

        // No lock at all: two attempts, then ERROR.
        pll_ok = 1'b0;
        n = 0;
        while (!pll_reset && n < 20) begin
            step();
            n++;
        end
        check("tmo_start", pll_reset, 1);
        for (int a = 0; a < 2; a++) begin
            pulse_len(n);
            check("tmo_pulse", n, 4);
            n = 0;
            while (!pll_reset && n < 100) begin
                step();
                n++;
            end
            check("tmo_wlock_len", n, 20);
        end
        check("err_state", {err, pll_reset, clk_ready, req_ready, busy}, 5'b11010);
        repeat (3) step();
        check("err_parked", {err, pll_reset}, 2'b11);
        do_req('{3'd4, 1'b1, 3'd1, 1'b0});
        check("err_after_bad_req", err, 1);
        pll_ok = 1'b1;
        do_req('{3'd1, 1'b0, 3'd1, 1'b0});
        wait_lock(-1, n);
        check("err_recover", {clk_ready, err, busy}, 3'b100);

        // Asynchronous reset in the middle of a WLOCK.
        do_req('{3'd3, 1'b0, 3'd3, 1'b0});
        repeat (2) step();
        rst = 1'b1;
        #1;
        check("midrst_flags", {pll_reset, busy, clk_ready, err, req_ready, cfg_err}, 6'b110000);
        check("midrst_codes", {idsel, fbdsel, odsel}, exp_codes(0));
        check("midrst_cur_cfg", cur_cfg, 0);
        step();
        step();
        rst = 1'b0;
        pulse_len(n);
        check("midrst_pulse", n, 4);
        wait_lock(-1, n);
        check("midrst_relock", (n >= 15 && n <= 17), 1);
        check("midrst_final", {clk_ready, cur_cfg, idsel, fbdsel, odsel}, {1'b1, 3'd0, exp_codes(0)});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rpll_reconfig_ctrl.md
Name: rpll_reconfig_ctrl

Overview:
- Sequences the GW1NZ-1 rPLL used as the acquisition sample clock.
- Selects one of NUM_CFG divider presets and drives the PLL dynamic IDSEL/FBDSEL/ODSEL codes, so the sample rate changes at runtime without a rebuild.
- Pulses the PLL RESET, waits for LOCK with a timeout and retries, then asserts clk_ready once lock has been stable.
- Runs on the 27 MHz board clock that also feeds the PLL; downstream acquisition logic gates on clk_ready.

Parameters:
- NUM_CFG, 4, number of divider presets in the shared preset table.
- CFG_W, 3, width of the preset index.
- RESET_CYCLES, 16, clk cycles pll_reset is held high per attempt.
- LOCK_TIMEOUT, 65535, clk cycles to wait for synchronized lock per attempt.
- STABLE_CYCLES, 256, consecutive clk cycles synchronized lock must stay high before clk_ready.
- MAX_RETRY, 3, lock attempts per request before entering ERROR.

Ports:
- clk  in  1  27 MHz board clock, also the PLL input clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request to switch to preset req_cfg.
- req_cfg  in  CFG_W  requested preset index.
- req_ready  out  1  high in READY or ERROR; a request is accepted when req_valid & req_ready.
- cfg_err  out  1  one-cycle pulse when an accepted req_cfg >= NUM_CFG.
- pll_lock  in  1  rPLL LOCK, asynchronous to clk.
- pll_reset  out  1  to rPLL RESET.
- idsel  out  6  to rPLL IDSEL.
- fbdsel  out  6  to rPLL FBDSEL.
- odsel  out  6  to rPLL ODSEL.
- cur_cfg  out  CFG_W  preset currently applied.
- clk_ready  out  1  PLL output valid for downstream use.
- busy  out  1  high in every state except READY and ERROR.
- err  out  1  high in ERROR.

Behaviour:
- Lock synchronization: pll_lock passes through a 2-flop synchronizer to lock_s; every reference to lock below means lock_s.
- Values while rst is high:
  - pll_reset=1, busy=1.
  - idsel/fbdsel/odsel = preset 0 codes, cur_cfg=0.
  - clk_ready=0, err=0, req_ready=0, cfg_err=0.
  - retry count=0, state=PRST.
- Code outputs are registered. They change only on an accepted valid request and stay stable for the whole sequence.
- PRST:
  - pll_reset=1 for exactly RESET_CYCLES cycles, then go to WLOCK.
  - Timer clears on entry.
- WLOCK:
  - pll_reset=0; the timer counts.
  - lock high -> STABLE.
  - Timer reaches LOCK_TIMEOUT -> increment retry. If retry < MAX_RETRY, go to PRST; otherwise go to ERROR.
- STABLE:
  - Counts consecutive cycles with lock high.
  - lock low -> back to WLOCK. The WLOCK timer is not reset, so the timeout covers the whole attempt.
  - Count reaches STABLE_CYCLES -> READY and clear retry.
- READY:
  - clk_ready=1, req_ready=1.
  - lock low -> clk_ready=0 on the next cycle and go to PRST. Retry was already cleared, so this starts a fresh set of attempts.
- ERROR:
  - err=1, pll_reset=1 (PLL parked), clk_ready=0, req_ready=1.
  - Leaves ERROR only through an accepted request or rst.
- Accepted request, valid index (from READY or ERROR):
  - Next cycle: clk_ready=0 and err=0.
  - Codes load from the preset table; cur_cfg=req_cfg; retry=0.
  - Go to PRST, so pll_reset rises in the same cycle the codes change.
  - A request for the current preset still runs the full sequence.
- Accepted request, invalid index:
  - cfg_err pulses for one cycle.
  - State, codes and cur_cfg are unchanged.
- req_valid while busy: ignored, not queued. The requester holds req_valid until req_ready.
- rst asserted mid-sequence: immediately returns to the reset values. On release, preset 0 is re-locked starting from PRST.
- Counters are saturating and sized with clog2 of the largest of RESET_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES, plus 1.

Decomposition:
- Package rpll_cfg_pkg holds:
  - the state enum {PRST, WLOCK, STABLE, READY, ERROR};
  - the preset table as constant arrays of 6-bit IDSEL/FBDSEL/ODSEL codes, in Gowin's inverted dynamic-select encoding;
  - NUM_CFG.
- Sub-module sync_2ff (1-bit, reset to 0) for pll_lock; it is reused for other async inputs.

Test Plan:
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
- Power-up: release rst, model raises lock 6 cycles after pll_reset falls -> pll_reset high for exactly 4 cycles; clk_ready rises 6+2+8 (±1) cycles after pll_reset falls; codes = preset 0.
- Switch: in READY, request cfg 2 -> same cycle codes = preset 2, cur_cfg=2, pll_reset=1, clk_ready=0; re-lock gives clk_ready=1 and busy=0.
- Timeout/retry: lock held low -> two PRST pulses, each 4 cycles, 20 WLOCK cycles each; then err=1, pll_reset=1; a request for cfg 1 with lock working clears err and reaches READY.
- Glitch: lock drops for 3 cycles during STABLE -> stable count restarts and clk_ready is delayed; lock drop in READY -> clk_ready falls within 3 cycles and pll_reset pulses 4 cycles.
- Invalid request: req_cfg=5 in READY -> one-cycle cfg_err, cur_cfg and codes unchanged, clk_ready stays 1.
- Mid-sequence reset: assert rst during WLOCK of cfg 3 -> outputs return to reset values asynchronously; after release, preset 0 locks.
